// File: rtl/crc_pkg.sv
// Shared types and default CRC-model constants for the CRC transmit framer.
package crc_pkg;

  typedef enum logic [0:0] {
    StData,
    StCrc
  } state_e;

  // Defaults describe CRC-16/BUYPASS over byte beats.
  localparam logic [63:0] DefaultPoly      = 64'h8005;
  localparam int unsigned DefaultCrcSize   = 16;
  localparam int unsigned DefaultDataWidth = 8;
  localparam logic [63:0] DefaultInit      = 64'h0;
  localparam bit          DefaultRefIn     = 1'b0;
  localparam bit          DefaultRefOut    = 1'b0;
  localparam logic [63:0] DefaultXorOut    = 64'h0;

endpackage

// File: rtl/crc_calc.sv
// Parameterised bit-serial-unrolled CRC engine: one DATA_WIDTH beat per valid cycle.
module crc_calc
  import crc_pkg::*;
#(
  parameter logic [63:0] POLY       = DefaultPoly,
  parameter int unsigned CRC_SIZE   = DefaultCrcSize,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter logic [63:0] INIT       = DefaultInit,
  parameter bit          REF_IN     = DefaultRefIn,
  parameter bit          REF_OUT    = DefaultRefOut,
  parameter logic [63:0] XOR_OUT    = DefaultXorOut
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o
);

  logic [CRC_SIZE-1:0]   crc_q, crc_d;
  logic [DATA_WIDTH-1:0] din;
  logic [CRC_SIZE-1:0]   crc_ref;
  logic                  fb;

  always_comb begin
    din = data_i;
    if (REF_IN) begin
      for (int i = 0; i < int'(DATA_WIDTH); i++) din[i] = data_i[DATA_WIDTH-1-i];
    end
    // Process the beat MSB first, one polynomial step per bit.
    crc_d = crc_q;
    fb    = 1'b0;
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      fb    = crc_d[CRC_SIZE-1] ^ din[i];
      crc_d = {crc_d[CRC_SIZE-2:0], 1'b0};
      if (fb) crc_d = crc_d ^ POLY[CRC_SIZE-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || soft_reset_i) begin
      crc_q <= INIT[CRC_SIZE-1:0];
    end else if (valid_i) begin
      crc_q <= crc_d;
    end
  end

  always_comb begin
    crc_ref = crc_q;
    if (REF_OUT) begin
      for (int i = 0; i < int'(CRC_SIZE); i++) crc_ref[i] = crc_q[CRC_SIZE-1-i];
    end
    crc_o = crc_ref ^ XOR_OUT[CRC_SIZE-1:0];
  end

endmodule

// File: rtl/crc_tx_framer.sv
// Stream framer: forwards payload beats, then appends the frame CRC MSB beat first.
module crc_tx_framer
  import crc_pkg::*;
#(
  parameter logic [63:0] POLY       = DefaultPoly,
  parameter int unsigned CRC_SIZE   = DefaultCrcSize,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter logic [63:0] INIT       = DefaultInit,
  parameter bit          REF_IN     = DefaultRefIn,
  parameter bit          REF_OUT    = DefaultRefOut,
  parameter logic [63:0] XOR_OUT    = DefaultXorOut
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic [15:0]           frame_cnt_o
);

  localparam int unsigned CrcBeats = CRC_SIZE / DATA_WIDTH;
  localparam int unsigned KW       = (CrcBeats > 1) ? $clog2(CrcBeats) : 1;
  localparam logic [KW-1:0] KLast  = KW'(CrcBeats - 1);

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [CRC_SIZE-1:0]   crc;
  logic [DATA_WIDTH-1:0] crc_beat;
  logic                  out_free, accept, crc_load, last_beat, soft_reset;

  crc_calc #(
    .POLY       (POLY),
    .CRC_SIZE   (CRC_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT       (INIT),
    .REF_IN     (REF_IN),
    .REF_OUT    (REF_OUT),
    .XOR_OUT    (XOR_OUT)
  ) u_crc_calc (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .soft_reset_i (soft_reset),
    .valid_i      (accept),
    .data_i       (s_data_i),
    .crc_o        (crc)
  );

  always_comb begin
    out_free   = !m_valid_q || m_ready_i;
    s_ready_o  = (state_q == StData) && out_free;
    accept     = s_valid_i && s_ready_o;
    crc_load   = (state_q == StCrc) && out_free;
    last_beat  = (k_q == KLast);
    soft_reset = crc_load && last_beat;
    crc_beat   = DATA_WIDTH'(crc >> ((CrcBeats - 1 - int'(k_q)) * DATA_WIDTH));
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    frame_cnt_d = frame_cnt_q;
    if (m_valid_q && m_ready_i && m_last_q) frame_cnt_d = frame_cnt_q + 16'd1;
    if (accept) begin
      m_data_d  = s_data_i;
      m_valid_d = 1'b1;
      m_last_d  = 1'b0;
      if (s_last_i) begin
        state_d = StCrc;
        k_d     = '0;
      end
    end else if (crc_load) begin
      m_data_d  = crc_beat;
      m_valid_d = 1'b1;
      m_last_d  = last_beat;
      k_d       = k_q + 1'b1;
      if (last_beat) state_d = StData;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StData;
      k_q         <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_data_o    = m_data_q;
  assign m_valid_o   = m_valid_q;
  assign m_last_o    = m_last_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_crc_tx_framer.sv
// Scoreboard bench for crc_tx_framer: a default instance and a reflected-CRC instance.
module tb_crc_tx_framer;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [8:0] beat_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b1;

  logic       s_ready_a, m_valid_a, m_last_a;
  logic [7:0] m_data_a;
  logic [15:0] cnt_a;
  logic       s_ready_b, m_valid_b, m_last_b;
  logic [7:0] m_data_b;
  logic [15:0] cnt_b;

  crc_tx_framer dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_last_i    (s_last),
    .s_ready_o   (s_ready_a),
    .m_data_o    (m_data_a),
    .m_valid_o   (m_valid_a),
    .m_last_o    (m_last_a),
    .m_ready_i   (m_ready),
    .frame_cnt_o (cnt_a)
  );

  crc_tx_framer #(
    .REF_IN  (1'b1),
    .REF_OUT (1'b1)
  ) dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_last_i    (s_last),
    .s_ready_o   (s_ready_b),
    .m_data_o    (m_data_b),
    .m_valid_o   (m_valid_b),
    .m_last_o    (m_last_b),
    .m_ready_i   (m_ready),
    .frame_cnt_o (cnt_b)
  );

  int      n_cmp = 0;
  int      n_err = 0;
  int      cyc = 0;
  int      stall_err = 0;
  bit      rnd_ready = 1'b0;
  beat_q_t obs_a, obs_b;
  int      obs_cyc[$];
  logic    prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;
  byte_q_t msg;

  // Downstream ready: held high, or random when backpressure is being exercised.
  always @(posedge clk) begin
    #1;
    m_ready = rnd_ready ? 1'(($urandom % 2)) : 1'b1;
  end

  // Output monitor: records every handshake and checks data stability while stalled.
  always @(negedge clk) begin
    cyc++;
    if (!rst && prev_stall && !(m_valid_a && ({m_last_a, m_data_a} == prev_beat))) stall_err++;
    prev_stall = !rst && m_valid_a && !m_ready;
    prev_beat  = {m_last_a, m_data_a};
    if (m_valid_a && m_ready) begin
      obs_a.push_back({m_last_a, m_data_a});
      obs_cyc.push_back(cyc);
    end
    if (m_valid_b && m_ready) obs_b.push_back({m_last_b, m_data_b});
  end

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    obs_a.delete();
    obs_b.delete();
    obs_cyc.delete();
    stall_err = 0;
  endtask

  task automatic send_frame(input byte_q_t d);
    for (int i = 0; i < d.size(); i++) begin
      int t = 0;
      s_data  = d[i];
      s_last  = (i == d.size() - 1);
      s_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (s_ready_a) break;
        t++;
        if (t > 500) begin
          n_cmp++;
          n_err++;
          $display("FAIL send_timeout: got s_ready=0 for %0d cycles, want 1", t);
          break;
        end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 600 && obs_a.size() < n; t++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (s_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", s_ready_a); end
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid_a); end
    n_cmp++; if (m_last_a !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b want 0", m_last_a); end
    n_cmp++; if (m_data_a !== 8'h00) begin n_err++; $display("FAIL reset_m_data: got %h want 00", m_data_a); end
    n_cmp++; if (cnt_a !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", cnt_a); end
  endtask

  task automatic test_basic(input string name, input bit random_ready);
    beat_q_t exp;
    logic [8:0] got;
    do_reset();
    foreach (msg[i]) exp.push_back({1'b0, msg[i]});
    exp.push_back({1'b0, 8'hFE});
    exp.push_back({1'b1, 8'hE8});
    rnd_ready = random_ready;
    send_frame(msg);
    wait_out(exp.size());
    rnd_ready = 1'b0;
    n_cmp++;
    if (obs_a.size() !== exp.size()) begin
      n_err++; $display("FAIL %s_len: got %0d beats want %0d", name, obs_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < obs_a.size()) ? obs_a[i] : 9'hx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL %s_beat%0d: got last=%b data=%h want last=%b data=%h",
                          name, i, got[8], got[7:0], exp[i][8], exp[i][7:0]);
      end
    end
    n_cmp++; if (cnt_a !== 16'd1) begin n_err++; $display("FAIL %s_frame_cnt: got %0d want 1", name, cnt_a); end
    n_cmp++; if (stall_err !== 0) begin n_err++; $display("FAIL %s_stall_hold: got %0d unstable cycles want 0", name, stall_err); end
  endtask

  task automatic test_reflected();
    beat_q_t exp;
    logic [8:0] got;
    do_reset();
    foreach (msg[i]) exp.push_back({1'b0, msg[i]});
    exp.push_back({1'b0, 8'hBB});
    exp.push_back({1'b1, 8'h3D});
    send_frame(msg);
    wait_out(exp.size());
    n_cmp++;
    if (obs_b.size() !== exp.size()) begin
      n_err++; $display("FAIL refl_len: got %0d beats want %0d", obs_b.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < obs_b.size()) ? obs_b[i] : 9'hx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL refl_beat%0d: got last=%b data=%h want last=%b data=%h",
                          i, got[8], got[7:0], exp[i][8], exp[i][7:0]);
      end
    end
    n_cmp++; if (cnt_b !== 16'd1) begin n_err++; $display("FAIL refl_frame_cnt: got %0d want 1", cnt_b); end
  endtask

  task automatic test_back_to_back();
    beat_q_t exp;
    logic [8:0] got;
    int span;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      foreach (msg[i]) exp.push_back({1'b0, msg[i]});
      exp.push_back({1'b0, 8'hFE});
      exp.push_back({1'b1, 8'hE8});
    end
    send_frame(msg);
    send_frame(msg);
    wait_out(exp.size());
    n_cmp++;
    if (obs_a.size() !== exp.size()) begin
      n_err++; $display("FAIL b2b_len: got %0d beats want %0d", obs_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < obs_a.size()) ? obs_a[i] : 9'hx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL b2b_beat%0d: got last=%b data=%h want last=%b data=%h",
                          i, got[8], got[7:0], exp[i][8], exp[i][7:0]);
      end
    end
    span = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size() - 1] - obs_cyc[0] : -1;
    n_cmp++; if (span !== exp.size() - 1) begin n_err++; $display("FAIL b2b_no_idle: got span %0d cycles want %0d", span, exp.size() - 1); end
    n_cmp++; if (cnt_a !== 16'd2) begin n_err++; $display("FAIL b2b_frame_cnt: got %0d want 2", cnt_a); end
  endtask

  task automatic test_single_beat();
    beat_q_t exp;
    byte_q_t one;
    logic [8:0] got;
    do_reset();
    one.push_back(8'h00);
    exp.push_back({1'b0, 8'h00});
    exp.push_back({1'b0, 8'h00});
    exp.push_back({1'b1, 8'h00});
    send_frame(one);
    wait_out(exp.size());
    n_cmp++;
    if (obs_a.size() !== exp.size()) begin
      n_err++; $display("FAIL single_len: got %0d beats want %0d", obs_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < obs_a.size()) ? obs_a[i] : 9'hx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL single_beat%0d: got last=%b data=%h want last=%b data=%h",
                          i, got[8], got[7:0], exp[i][8], exp[i][7:0]);
      end
    end
    n_cmp++; if (cnt_a !== 16'd1) begin n_err++; $display("FAIL single_frame_cnt: got %0d want 1", cnt_a); end
  endtask

  task automatic test_mid_reset();
    beat_q_t exp;
    byte_q_t part;
    logic [8:0] got;
    do_reset();
    for (int i = 0; i < 4; i++) part.push_back(msg[i]);
    // Four beats without s_last leave the frame open when reset hits.
    for (int i = 0; i < 4; i++) begin
      s_data = part[i]; s_last = 1'b0; s_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    do_reset();
    foreach (msg[i]) exp.push_back({1'b0, msg[i]});
    exp.push_back({1'b0, 8'hFE});
    exp.push_back({1'b1, 8'hE8});
    send_frame(msg);
    wait_out(exp.size());
    n_cmp++;
    if (obs_a.size() !== exp.size()) begin
      n_err++; $display("FAIL midrst_len: got %0d beats want %0d", obs_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < obs_a.size()) ? obs_a[i] : 9'hx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL midrst_beat%0d: got last=%b data=%h want last=%b data=%h",
                          i, got[8], got[7:0], exp[i][8], exp[i][7:0]);
      end
    end
    n_cmp++; if (cnt_a !== 16'd1) begin n_err++; $display("FAIL midrst_frame_cnt: got %0d want 1", cnt_a); end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
    test_reset();
    test_basic("basic", 1'b0);
    test_reflected();
    test_basic("backpressure", 1'b1);
    test_back_to_back();
    test_single_beat();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crc_tx_framer.md
CRC_TX_FRAMER -- requirements
Module: crc_tx_framer

Interface
REQ-001 SHALL have parameter POLY, default 64'h8005, CRC generator polynomial (implicit top bit).
REQ-002 SHALL have parameter CRC_SIZE, default 16, CRC width in bits; legal only as an integer multiple of DATA_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, stream beat width.
REQ-004 SHALL have parameters INIT (64'h0), REF_IN (0), REF_OUT (0), XOR_OUT (64'h0), with the standard CRC-model meanings.
REQ-005 SHALL have port clk_i, input, 1, single clock for all logic.
REQ-006 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port s_data_i, input, DATA_WIDTH, payload beat.
REQ-008 SHALL have port s_valid_i, input, 1, payload beat valid.
REQ-009 SHALL have port s_last_i, input, 1, final payload beat of frame.
REQ-010 SHALL have port s_ready_o, output, 1, payload beat accepted when s_valid_i && s_ready_o.
REQ-011 SHALL have port m_data_o, output, DATA_WIDTH, output beat (payload, then CRC).
REQ-012 SHALL have port m_valid_o, output, 1, output beat valid.
REQ-013 SHALL have port m_last_o, output, 1, final CRC beat of frame.
REQ-014 SHALL have port m_ready_i, input, 1, downstream accept.
REQ-015 SHALL have port frame_cnt_o, output, 16, completed-frame count.

Function
REQ-016 SHALL implement a two-state FSM: DATA (pass payload) and CRC (emit CRC_SIZE/DATA_WIDTH CRC beats).
REQ-017 SHALL define out_free = !m_valid_o || m_ready_i; all m_* outputs SHALL be registered.
REQ-018 In DATA, s_ready_o SHALL equal out_free; s_ready_o SHALL be 0 in CRC.
REQ-019 On a payload accept, m_data_o <= s_data_i, m_valid_o <= 1, m_last_o <= 0 on the next edge; latency 1 cycle, throughput 1 beat/cycle.
REQ-020 Each payload accept SHALL pulse valid_i of the CRC engine with the same beat.
REQ-021 A payload accept with s_last_i=1 SHALL move the FSM to CRC and clear beat index k to 0.
REQ-022 In CRC, when out_free, m_data_o <= crc_o[CRC_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH] (MSB beat first), m_valid_o <= 1, m_last_o <= (k == CRC_SIZE/DATA_WIDTH-1), k increments.
REQ-023 Loading the final CRC beat SHALL assert CRC engine soft_reset_i for that cycle and return the FSM to DATA.
REQ-024 When no load occurs and m_ready_i=1, m_valid_o and m_last_o SHALL clear next edge; m_data_o SHALL hold while m_valid_o && !m_ready_i.
REQ-025 frame_cnt_o SHALL increment by 1 on each handshake with m_last_o=1, wrapping 16'hFFFF -> 0.
REQ-026 A single-beat frame (s_last_i on first beat) SHALL be legal and produce 1 + CRC_SIZE/DATA_WIDTH output beats.
REQ-027 s_valid_i while in CRC SHALL be ignored (no accept, no CRC update); the next frame starts after return to DATA.
REQ-028 Back-to-back frames SHALL incur no idle cycle beyond the CRC beats when m_ready_i is held high.

Reset
REQ-029 rst_i SHALL force FSM=DATA, k=0, m_valid_o=0, m_last_o=0, m_data_o=0, frame_cnt_o=0, CRC register=INIT; s_ready_o SHALL be 1 in the cycle after rst_i deasserts.
REQ-030 rst_i asserted mid-frame SHALL abandon the frame; no partial CRC beats are emitted afterwards.

Structure
REQ-031 The FSM state enum and default CRC-model constants SHALL live in shared package crc_pkg.
REQ-032 SHALL instantiate crc_calc as the sole sub-module, with all CRC parameters passed through and clk_i/rst_i connected directly.

Verification
REQ-033 Defaults, frame "123456789" (8'h31..8'h39), m_ready_i=1 -> outputs 31..39, then FE, E8 with m_last_o on E8; frame_cnt_o=1.
REQ-034 REF_IN=1, REF_OUT=1, same frame -> CRC beats BB, 3D.
REQ-035 Same frame, m_ready_i toggling randomly -> identical output byte sequence; m_data_o stable whenever m_valid_o && !m_ready_i.
REQ-036 Two back-to-back frames "123456789" -> second also ends FE, E8 (soft reset verified); frame_cnt_o=2; no idle cycles between frames.
REQ-037 Single-beat frame 8'h00, defaults -> outputs 00, 00, 00 (CRC 16'h0000).
REQ-038 rst_i pulsed after 4 payload beats, then full "123456789" frame -> only the new frame's CRC FE, E8 is emitted; frame_cnt_o=1.
